// File: rtl/cache_mem_responder_pkg.sv
// rtl/cache_mem_responder_pkg.sv - shared types and state encodings for the cache memory responder
package cache_mem_responder_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [1:0] respstate_t;
  localparam respstate_t IDLE   = 2'd0;
  localparam respstate_t DGRANT = 2'd1;
  localparam respstate_t IGRANT = 2'd2;

  typedef enum logic {
    src_cpu = 1'b0,
    src_isi = 1'b1
  } src_t;

endpackage

// File: rtl/cache_mem_responder_if.sv
// rtl/cache_mem_responder_if.sv - cache request ports and single RAM port bundle
interface cache_mem_responder_if #(
  parameter int CPUS = 2
);
  import cache_mem_responder_pkg::*;

  logic [CPUS-1:0]       iREN;
  logic [CPUS-1:0][31:0] iaddr;
  logic [CPUS-1:0]       iwait;
  logic [CPUS-1:0][31:0] iload;
  logic [CPUS-1:0]       dREN;
  logic [CPUS-1:0]       dWEN;
  logic [CPUS-1:0][31:0] daddr;
  logic [CPUS-1:0][31:0] dstore;
  logic [CPUS-1:0]       dwait;
  logic [CPUS-1:0][31:0] dload;
  logic                  ramREN;
  logic                  ramWEN;
  logic [31:0]           ramaddr;
  logic [31:0]           ramstore;
  logic [31:0]           ramload;
  ramstate_t             ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/cache_mem_responder_rr_arbiter.sv
// rtl/cache_mem_responder_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic [PW-1:0] ptr_next
);

  int unsigned k;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = PW'(k);
      end
    end
    ptr_next = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + PW'(1);
  end

endmodule

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - arbitrates icache/dcache requests of all CPUs onto one RAM port
module cache_mem_responder
  import cache_mem_responder_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int DBURST = 2
) (
  input logic                  CLK,
  input logic                  nRST,
  cache_mem_responder_if.slave bus
);

  localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CW = $clog2(DBURST) + 1;

  respstate_t    state_q, state_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;

  logic [CPUS-1:0] w_gnt, r_gnt, i_gnt;
  logic [PW-1:0]   w_idx, r_idx, i_idx;
  logic [PW-1:0]   w_next, r_next, i_next;
  logic [CW-1:0]   cnt_inc;
  logic            access;

  // One arbiter per priority class, all sharing the same rotation pointer.
  rr_arbiter #(.N(CPUS), .PW(PW)) u_arb_wr (
    .req(bus.dWEN), .ptr(ptr_q), .gnt(w_gnt), .gnt_idx(w_idx), .ptr_next(w_next)
  );
  rr_arbiter #(.N(CPUS), .PW(PW)) u_arb_rd (
    .req(bus.dREN), .ptr(ptr_q), .gnt(r_gnt), .gnt_idx(r_idx), .ptr_next(r_next)
  );
  rr_arbiter #(.N(CPUS), .PW(PW)) u_arb_if (
    .req(bus.iREN), .ptr(ptr_q), .gnt(i_gnt), .gnt_idx(i_idx), .ptr_next(i_next)
  );

  assign access  = (bus.ramstate == ACCESS);
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|w_gnt) begin
          state_d = DGRANT; gnt_d = w_idx; ptr_d = w_next;
        end else if (|r_gnt) begin
          state_d = DGRANT; gnt_d = r_idx; ptr_d = r_next;
        end else if (|i_gnt) begin
          state_d = IGRANT; gnt_d = i_idx; ptr_d = i_next;
        end
      end
      DGRANT: begin
        if (!(bus.dREN[gnt_q] || bus.dWEN[gnt_q])) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (access) begin
          if (cnt_inc == CW'(DBURST)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      IGRANT: begin
        if (!bus.iREN[gnt_q] || access) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs depend only on registered grant plus the granted port's own inputs.
  always_comb begin
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (state_q == DGRANT) begin
      bus.ramWEN       = bus.dWEN[gnt_q];
      bus.ramREN       = bus.dREN[gnt_q] & ~bus.dWEN[gnt_q];
      bus.ramaddr      = bus.daddr[gnt_q];
      bus.ramstore     = bus.dstore[gnt_q];
      bus.dwait[gnt_q] = ~access;
      bus.dload[gnt_q] = bus.ramload;
    end else if (state_q == IGRANT) begin
      bus.ramREN       = bus.iREN[gnt_q];
      bus.ramaddr      = bus.iaddr[gnt_q];
      bus.iwait[gnt_q] = ~access;
      bus.iload[gnt_q] = bus.ramload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - directed self-checking bench for cache_mem_responder
module tb_cache_mem_responder;
  import cache_mem_responder_pkg::*;

  logic CLK;
  logic nRST;
  int   n_cmp;
  int   n_err;
  int   exp_cpu;
  int   g0;
  int   g1;

  cache_mem_responder_if #(.CPUS(2)) bus ();

  cache_mem_responder #(.CPUS(2), .DBURST(2)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    bus.iREN   = '0;
    bus.dREN   = '0;
    bus.dWEN   = '0;
    bus.iaddr  = '0;
    bus.daddr  = '0;
    bus.dstore = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    nRST  = 1'b0;
    clr();
    bus.ramstate = FREE;
    bus.ramload  = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_iwait", bus.iwait, 32'h3);
    chk("rst_dwait", bus.dwait, 32'h3);
    chk("rst_ramren", bus.ramREN, 32'h0);
    chk("rst_ramwen", bus.ramWEN, 32'h0);
    chk("rst_ramaddr", bus.ramaddr, 32'h0);
    chk("rst_ramstore", bus.ramstore, 32'h0);
    chk("rst_dload0", bus.dload[0], 32'h0);
    chk("rst_iload1", bus.iload[1], 32'h0);
    nRST = 1'b1;

    // single dcache read, ACCESS two cycles after the enable
    next(); bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h100; #1;
    chk("t2_c0_ren", bus.ramREN, 32'h0);
    next(); bus.ramstate = BUSY; #1;
    chk("t2_c1_ren", bus.ramREN, 32'h1);
    chk("t2_c1_addr", bus.ramaddr, 32'h100);
    chk("t2_c1_dwait", bus.dwait, 32'h3);
    next(); #1;
    chk("t2_c2_dwait", bus.dwait, 32'h3);
    next(); bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF; #1;
    chk("t2_c3_dwait", bus.dwait, 32'h2);
    chk("t2_c3_dload0", bus.dload[0], 32'hDEADBEEF);
    chk("t2_c3_dload1", bus.dload[1], 32'h0);
    next(); bus.daddr[0] = 32'h104; bus.ramload = 32'hCAFEF00D; #1;
    chk("t2_c4_addr", bus.ramaddr, 32'h104);
    chk("t2_c4_dload0", bus.dload[0], 32'hCAFEF00D);
    next(); clr(); bus.ramstate = FREE; #1;
    chk("t2_idle_ren", bus.ramREN, 32'h0);
    chk("t2_idle_dwait", bus.dwait, 32'h3);

    // burst lock: icache of CPU1 waits for both dcache words
    next(); bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h200; bus.iREN[1] = 1'b1; bus.iaddr[1] = 32'h0; #1;
    chk("t3_idle_ren", bus.ramREN, 32'h0);
    next(); bus.ramstate = ACCESS; #1;
    chk("t3_w0_addr", bus.ramaddr, 32'h200);
    chk("t3_w0_ren", bus.ramREN, 32'h1);
    chk("t3_w0_iwait", bus.iwait, 32'h3);
    chk("t3_w0_dwait", bus.dwait, 32'h2);
    next(); bus.daddr[0] = 32'h204; #1;
    chk("t3_w1_addr", bus.ramaddr, 32'h204);
    chk("t3_w1_iwait", bus.iwait, 32'h3);
    next(); bus.dREN[0] = 1'b0; bus.ramstate = FREE; #1;
    chk("t3_gap_ren", bus.ramREN, 32'h0);
    chk("t3_gap_iwait", bus.iwait, 32'h3);
    next(); bus.ramstate = ACCESS; bus.ramload = 32'h11112222; #1;
    chk("t3_if_ren", bus.ramREN, 32'h1);
    chk("t3_if_addr", bus.ramaddr, 32'h0);
    chk("t3_if_iwait", bus.iwait, 32'h1);
    chk("t3_if_iload1", bus.iload[1], 32'h11112222);
    chk("t3_if_iload0", bus.iload[0], 32'h0);
    chk("t3_if_dload0", bus.dload[0], 32'h0);
    next(); clr(); bus.ramstate = FREE; #1;
    chk("t3_end_iwait", bus.iwait, 32'h3);

    // class priority: write, then read, then ifetch
    next();
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h80;
    bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h300;
    bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h40; bus.dstore[0] = 32'h12345678; #1;
    chk("t4_idle_wen", bus.ramWEN, 32'h0);
    next(); bus.ramstate = ACCESS; #1;
    chk("t4_wr_wen", bus.ramWEN, 32'h1);
    chk("t4_wr_ren", bus.ramREN, 32'h0);
    chk("t4_wr_addr", bus.ramaddr, 32'h40);
    chk("t4_wr_store", bus.ramstore, 32'h12345678);
    chk("t4_wr_dwait", bus.dwait, 32'h2);
    next(); bus.daddr[0] = 32'h44; bus.dstore[0] = 32'h9ABCDEF0; #1;
    chk("t4_wr1_addr", bus.ramaddr, 32'h44);
    chk("t4_wr1_store", bus.ramstore, 32'h9ABCDEF0);
    next(); bus.dWEN[0] = 1'b0; bus.ramstate = FREE; #1;
    chk("t4_gap1_wen", bus.ramWEN, 32'h0);
    chk("t4_gap1_iwait", bus.iwait, 32'h3);
    next(); bus.ramstate = ACCESS; bus.ramload = 32'h55AA55AA; #1;
    chk("t4_rd_ren", bus.ramREN, 32'h1);
    chk("t4_rd_addr", bus.ramaddr, 32'h300);
    chk("t4_rd_dwait", bus.dwait, 32'h1);
    chk("t4_rd_dload1", bus.dload[1], 32'h55AA55AA);
    next(); #1;
    chk("t4_rd1_dwait", bus.dwait, 32'h1);
    next(); bus.dREN[1] = 1'b0; bus.ramstate = FREE; #1;
    chk("t4_gap2_ren", bus.ramREN, 32'h0);
    next(); bus.ramstate = ACCESS; bus.ramload = 32'h77778888; #1;
    chk("t4_if_ren", bus.ramREN, 32'h1);
    chk("t4_if_addr", bus.ramaddr, 32'h80);
    chk("t4_if_iwait", bus.iwait, 32'h2);
    chk("t4_if_iload0", bus.iload[0], 32'h77778888);
    next(); clr(); bus.ramstate = FREE; #1;
    chk("t4_end_ren", bus.ramREN, 32'h0);

    // round-robin between two continuous dcache readers; pointer sits at CPU1 here
    next(); bus.dREN = 2'b11; bus.daddr[0] = 32'h1000; bus.daddr[1] = 32'h2000; #1;
    chk("t5_idle_ren", bus.ramREN, 32'h0);
    exp_cpu = 1;
    g0 = 0;
    g1 = 0;
    for (int b = 0; b < 8; b++) begin
      next(); bus.ramstate = ACCESS; #1;
      chk("t5_addr", bus.ramaddr, (exp_cpu == 1) ? 32'h2000 : 32'h1000);
      if (bus.ramaddr == 32'h2000) g1++;
      else if (bus.ramaddr == 32'h1000) g0++;
      next(); #1;
      chk("t5_dwait", bus.dwait, (exp_cpu == 1) ? 32'h1 : 32'h2);
      next(); bus.ramstate = FREE; #1;
      chk("t5_gap_ren", bus.ramREN, 32'h0);
      exp_cpu = 1 - exp_cpu;
    end
    chk("t5_grants_cpu0", g0, 32'd4);
    chk("t5_grants_cpu1", g1, 32'd4);

    // abort after first word, then a fresh burst must need two words again
    clr();
    bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h500; bus.dstore[0] = 32'hA5A5A5A5;
    bus.iREN[1] = 1'b1; bus.iaddr[1] = 32'h600;
    next(); bus.ramstate = ACCESS; #1;
    chk("t6_w0_wen", bus.ramWEN, 32'h1);
    chk("t6_w0_addr", bus.ramaddr, 32'h500);
    next(); bus.dWEN[0] = 1'b0; bus.ramstate = FREE; #1;
    chk("t6_abort_wen", bus.ramWEN, 32'h0);
    chk("t6_abort_ren", bus.ramREN, 32'h0);
    next(); #1;
    chk("t6_idle_ren", bus.ramREN, 32'h0);
    next(); bus.ramstate = ACCESS; bus.ramload = 32'h600D600D; #1;
    chk("t6_if_ren", bus.ramREN, 32'h1);
    chk("t6_if_addr", bus.ramaddr, 32'h600);
    chk("t6_if_iwait", bus.iwait, 32'h1);
    next(); bus.iREN[1] = 1'b0; bus.ramstate = FREE;
    bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h540; bus.dstore[0] = 32'h1; #1;
    chk("t6_idle2_wen", bus.ramWEN, 32'h0);
    next(); bus.ramstate = ACCESS; #1;
    chk("t6_b_wen", bus.ramWEN, 32'h1);
    chk("t6_b_addr", bus.ramaddr, 32'h540);
    next(); bus.ramstate = ERROR; #1;
    chk("t6_cnt_clear", bus.ramWEN, 32'h1);
    chk("t6_err_dwait", bus.dwait, 32'h3);
    next(); bus.ramstate = ACCESS; #1;
    chk("t6_b1_dwait", bus.dwait, 32'h2);
    next(); clr(); bus.ramstate = FREE; #1;
    chk("t6_end_wen", bus.ramWEN, 32'h0);

    // asynchronous reset in the middle of a dcache grant
    next(); bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h700;
    next(); bus.ramstate = ACCESS; #1;
    chk("t1_pre_ren", bus.ramREN, 32'h1);
    #1 nRST = 1'b0;
    #1;
    chk("t1_rst_dwait", bus.dwait, 32'h3);
    chk("t1_rst_iwait", bus.iwait, 32'h3);
    chk("t1_rst_ren", bus.ramREN, 32'h0);
    chk("t1_rst_wen", bus.ramWEN, 32'h0);
    clr(); bus.ramstate = FREE;
    next();
    next(); nRST = 1'b1; #1;
    chk("t1_idle_ren", bus.ramREN, 32'h0);
    bus.dREN = 2'b11; bus.daddr[0] = 32'h800; bus.daddr[1] = 32'h900;
    next(); bus.ramstate = ACCESS; #1;
    chk("t1_ptr_reset_addr", bus.ramaddr, 32'h800);
    next(); clr(); bus.ramstate = FREE;
    next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
